// File: rtl/regfile_wb_arbiter.sv
// Shares the GPR write port between the pipeline WB stage (priority) and the mult/div unit,
// with a starvation guard for the latter; one registered slot drives and bypasses the write port.
module regfile_wb_arbiter #(
    parameter int STARVE_LIMIT = 3,
    parameter int CNT_W        = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [4:0]       req0_addr,
    input  logic [31:0]      req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [4:0]       req1_addr,
    input  logic [31:0]      req1_data,
    output logic             req1_ready,
    output logic             rf_we,
    output logic [4:0]       rf_a3,
    output logic [31:0]      rf_wd,
    output logic             pend_valid,
    output logic [4:0]       pend_addr,
    output logic [31:0]      pend_data,
    output logic [CNT_W-1:0] starve_cnt
);

    logic             w_force1;
    logic             w_grant0;
    logic             w_grant1;
    logic             w_grant;
    logic [4:0]       w_addr;
    logic [31:0]      w_data;

    logic             r_we;
    logic [4:0]       r_a3;
    logic [31:0]      r_wd;
    logic [CNT_W-1:0] r_cnt;

    // Readies ignore the requester's own valid so a requester may wait on ready before asserting.
    assign w_force1   = (r_cnt == CNT_W'(STARVE_LIMIT));
    assign req0_ready = !(req1_valid && w_force1);
    assign req1_ready = !req0_valid || w_force1;

    assign w_grant0 = req0_valid && req0_ready;
    assign w_grant1 = req1_valid && req1_ready;
    assign w_grant  = w_grant0 || w_grant1;
    assign w_addr   = w_grant0 ? req0_addr : req1_addr;
    assign w_data   = w_grant0 ? req0_data : req1_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we  <= 1'b0;
            r_a3  <= 5'd0;
            r_wd  <= 32'd0;
            r_cnt <= '0;
        end else begin
            // $0 writes complete the handshake but never raise the write enable.
            r_we <= w_grant && (w_addr != 5'd0);
            if (w_grant) begin
                r_a3 <= w_addr;
                r_wd <= w_data;
            end
            if (w_grant1)
                r_cnt <= '0;
            else if (req1_valid && !req1_ready && !w_force1)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign rf_we      = r_we;
    assign rf_a3      = r_a3;
    assign rf_wd      = r_wd;
    assign pend_valid = r_we;
    assign pend_addr  = r_a3;
    assign pend_data  = r_wd;
    assign starve_cnt = r_cnt;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: per-cycle stimulus tables with hand-derived readies and counts,
// expected write-port contents queued at each grant and popped one cycle later.
module tb_regfile_wb_arbiter;

    typedef struct packed {
        logic        v0;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic        e0;
        logic        e1;
        logic [3:0]  ecnt;
    } stim_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 1'b0;
    logic [4:0]  req0_addr = 5'd0;
    logic [31:0] req0_data = 32'd0;
    logic        req0_ready;
    logic        req1_valid = 1'b0;
    logic [4:0]  req1_addr = 5'd0;
    logic [31:0] req1_data = 32'd0;
    logic        req1_ready;
    logic        rf_we;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd;
    logic        pend_valid;
    logic [4:0]  pend_addr;
    logic [31:0] pend_data;
    logic [3:0]  starve_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    wr_t q[$];
    logic [4:0]  exp_a3 = 5'd0;
    logic [31:0] exp_wd = 32'd0;
    logic [31:0] gpr [32] = '{default: 32'd0};

    regfile_wb_arbiter #(.STARVE_LIMIT(3), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd),
        .pend_valid(pend_valid), .pend_addr(pend_addr), .pend_data(pend_data),
        .starve_cnt(starve_cnt)
    );

    always #5 clk = ~clk;

    // Register file model: commits whatever the port presents, including $0, so a stray
    // $0 enable shows up on readback.
    always @(posedge clk) begin
        if (rf_we) gpr[rf_a3] <= rf_wd;
    end

    task automatic drive(input stim_t s);
        req0_valid = s.v0; req0_addr = s.a0; req0_data = s.d0;
        req1_valid = s.v1; req1_addr = s.a1; req1_data = s.d1;
    endtask

    // Queue what the write port must show next cycle, from the expected readies, then advance.
    task automatic tick(input logic e0, input logic e1);
        if (req0_valid && e0) begin
            exp_a3 = req0_addr; exp_wd = req0_data;
            q.push_back('{we: (req0_addr != 5'd0), a: exp_a3, d: exp_wd});
        end else if (req1_valid && e1) begin
            exp_a3 = req1_addr; exp_wd = req1_data;
            q.push_back('{we: (req1_addr != 5'd0), a: exp_a3, d: exp_wd});
        end else begin
            q.push_back('{we: 1'b0, a: exp_a3, d: exp_wd});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if ({rf_we, rf_a3, rf_wd, pend_valid, pend_addr, pend_data, starve_cnt} !== 80'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: we=%b a3=%0d wd=%h pv=%b cnt=%0d, want all zero",
                     rf_we, rf_a3, rf_wd, pend_valid, starve_cnt);
        end
        n_cmp++;
        if ({req0_ready, req1_ready} !== 2'b11) begin
            n_bad++;
            $display("FAIL reset_ready: rdy0/rdy1=%b%b want 11", req0_ready, req1_ready);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        exp_a3 = 5'd0; exp_wd = 32'd0;
        q.push_back('{we: 1'b0, a: 5'd0, d: 32'd0});
    endtask

    task automatic test_single();
        stim_t t[3];
        wr_t e;
        t[0] = '{1'b1, 5'd8, 32'h12345678, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 4'd0};
        t[1] = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 4'd0};
        t[2] = t[1];
        for (int i = 0; i < 3; i++) begin
            drive(t[i]);
            #1;
            n_cmp++;
            if ({req0_ready, req1_ready, starve_cnt} !== {t[i].e0, t[i].e1, t[i].ecnt}) begin
                n_bad++;
                $display("FAIL single_ready c%0d: rdy0/rdy1/cnt=%b/%b/%0d want %b/%b/%0d",
                         i, req0_ready, req1_ready, starve_cnt, t[i].e0, t[i].e1, t[i].ecnt);
            end
            e = q.pop_front();
            n_cmp++;
            if ({rf_we, rf_a3, rf_wd, pend_valid, pend_addr, pend_data} !== {e.we, e.a, e.d, e.we, e.a, e.d}) begin
                n_bad++;
                $display("FAIL single_port c%0d: we/a3/wd/pv=%b/%0d/%h/%b want %b/%0d/%h/%b",
                         i, rf_we, rf_a3, rf_wd, pend_valid, e.we, e.a, e.d, e.we);
            end
            tick(t[i].e0, t[i].e1);
        end
    endtask

    task automatic test_back_to_back();
        stim_t t[6];
        wr_t e;
        for (int i = 0; i < 4; i++)
            t[i] = '{1'b1, 5'(i + 1), 32'(i + 1), 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 4'd0};
        t[4] = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 4'd0};
        t[5] = t[4];
        for (int i = 0; i < 6; i++) begin
            drive(t[i]);
            #1;
            n_cmp++;
            if ({req0_ready, req1_ready, starve_cnt} !== {t[i].e0, t[i].e1, t[i].ecnt}) begin
                n_bad++;
                $display("FAIL b2b_ready c%0d: rdy0/rdy1/cnt=%b/%b/%0d want %b/%b/%0d",
                         i, req0_ready, req1_ready, starve_cnt, t[i].e0, t[i].e1, t[i].ecnt);
            end
            e = q.pop_front();
            n_cmp++;
            if ({rf_we, rf_a3, rf_wd, pend_valid, pend_addr, pend_data} !== {e.we, e.a, e.d, e.we, e.a, e.d}) begin
                n_bad++;
                $display("FAIL b2b_port c%0d: we/a3/wd=%b/%0d/%h want %b/%0d/%h",
                         i, rf_we, rf_a3, rf_wd, e.we, e.a, e.d);
            end
            tick(t[i].e0, t[i].e1);
        end
        for (int r = 1; r <= 4; r++) begin
            n_cmp++;
            if (gpr[r] !== 32'(r)) begin
                n_bad++;
                $display("FAIL b2b_gpr%0d: got %h want %h", r, gpr[r], 32'(r));
            end
        end
    endtask

    task automatic test_starvation();
        stim_t t[6];
        wr_t e;
        for (int i = 0; i < 3; i++)
            t[i] = '{1'b1, 5'(10 + i), 32'(256 + i), 1'b1, 5'd9, 32'hAAAA0001, 1'b1, 1'b0, 4'(i)};
        t[3] = '{1'b1, 5'd13, 32'h103, 1'b1, 5'd9, 32'hAAAA0001, 1'b0, 1'b1, 4'd3};
        t[4] = '{1'b1, 5'd13, 32'h103, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 4'd0};
        t[5] = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 4'd0};
        for (int i = 0; i < 6; i++) begin
            drive(t[i]);
            #1;
            n_cmp++;
            if ({req0_ready, req1_ready, starve_cnt} !== {t[i].e0, t[i].e1, t[i].ecnt}) begin
                n_bad++;
                $display("FAIL starve_ready c%0d: rdy0/rdy1/cnt=%b/%b/%0d want %b/%b/%0d",
                         i, req0_ready, req1_ready, starve_cnt, t[i].e0, t[i].e1, t[i].ecnt);
            end
            e = q.pop_front();
            n_cmp++;
            if ({rf_we, rf_a3, rf_wd, pend_valid, pend_addr, pend_data} !== {e.we, e.a, e.d, e.we, e.a, e.d}) begin
                n_bad++;
                $display("FAIL starve_port c%0d: we/a3/wd=%b/%0d/%h want %b/%0d/%h",
                         i, rf_we, rf_a3, rf_wd, e.we, e.a, e.d);
            end
            tick(t[i].e0, t[i].e1);
        end
        n_cmp++;
        if (gpr[9] !== 32'hAAAA0001) begin
            n_bad++;
            $display("FAIL starve_gpr9: got %h want aaaa0001", gpr[9]);
        end
    endtask

    task automatic test_zero_write();
        stim_t t[3];
        wr_t e;
        t[0] = '{1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 1'b1, 4'd0};
        t[1] = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 4'd0};
        t[2] = t[1];
        for (int i = 0; i < 3; i++) begin
            drive(t[i]);
            #1;
            n_cmp++;
            if ({req0_ready, req1_ready, starve_cnt} !== {t[i].e0, t[i].e1, t[i].ecnt}) begin
                n_bad++;
                $display("FAIL zero_ready c%0d: rdy0/rdy1/cnt=%b/%b/%0d want %b/%b/%0d",
                         i, req0_ready, req1_ready, starve_cnt, t[i].e0, t[i].e1, t[i].ecnt);
            end
            e = q.pop_front();
            n_cmp++;
            if ({rf_we, rf_a3, rf_wd, pend_valid, pend_addr, pend_data} !== {e.we, e.a, e.d, e.we, e.a, e.d}) begin
                n_bad++;
                $display("FAIL zero_port c%0d: we/pv/a3/wd=%b/%b/%0d/%h want %b/%b/%0d/%h",
                         i, rf_we, pend_valid, rf_a3, rf_wd, e.we, e.we, e.a, e.d);
            end
            tick(t[i].e0, t[i].e1);
        end
        n_cmp++;
        if (gpr[0] !== 32'd0) begin
            n_bad++;
            $display("FAIL zero_gpr0: got %h want 00000000", gpr[0]);
        end
    endtask

    task automatic test_collision();
        stim_t t[4];
        wr_t e;
        t[0] = '{1'b1, 5'd4, 32'h1, 1'b1, 5'd4, 32'h2, 1'b1, 1'b0, 4'd0};
        t[1] = '{1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h2, 1'b1, 1'b1, 4'd1};
        t[2] = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 4'd0};
        t[3] = t[2];
        for (int i = 0; i < 4; i++) begin
            drive(t[i]);
            #1;
            n_cmp++;
            if ({req0_ready, req1_ready, starve_cnt} !== {t[i].e0, t[i].e1, t[i].ecnt}) begin
                n_bad++;
                $display("FAIL collide_ready c%0d: rdy0/rdy1/cnt=%b/%b/%0d want %b/%b/%0d",
                         i, req0_ready, req1_ready, starve_cnt, t[i].e0, t[i].e1, t[i].ecnt);
            end
            e = q.pop_front();
            n_cmp++;
            if ({rf_we, rf_a3, rf_wd, pend_valid, pend_addr, pend_data} !== {e.we, e.a, e.d, e.we, e.a, e.d}) begin
                n_bad++;
                $display("FAIL collide_port c%0d: we/a3/wd=%b/%0d/%h want %b/%0d/%h",
                         i, rf_we, rf_a3, rf_wd, e.we, e.a, e.d);
            end
            tick(t[i].e0, t[i].e1);
        end
        n_cmp++;
        if (gpr[4] !== 32'h2) begin
            n_bad++;
            $display("FAIL collide_gpr4: got %h want 00000002", gpr[4]);
        end
    endtask

    task automatic test_reset_mid_write();
        stim_t s;
        s = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd7, 32'h7, 1'b1, 1'b0, 4'd0};
        drive(s);
        #1;
        n_cmp++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_bad++;
            $display("FAIL rstmid_ready: rdy0/rdy1=%b%b want 10", req0_ready, req1_ready);
        end
        tick(1'b1, 1'b0);
        drive('0);
        #1;
        n_cmp++;
        if ({rf_we, rf_a3, rf_wd, starve_cnt} !== {1'b1, 5'd5, 32'hDEADBEEF, 4'd1}) begin
            n_bad++;
            $display("FAIL rstmid_staged: we/a3/wd/cnt=%b/%0d/%h/%0d want 1/5/deadbeef/1",
                     rf_we, rf_a3, rf_wd, starve_cnt);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({rf_we, rf_a3, rf_wd, pend_valid, pend_addr, pend_data, starve_cnt} !== 80'd0) begin
            n_bad++;
            $display("FAIL rstmid_async: we/a3/wd/pv/cnt=%b/%0d/%h/%b/%0d want all zero",
                     rf_we, rf_a3, rf_wd, pend_valid, starve_cnt);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (gpr[5] !== 32'd0) begin
            n_bad++;
            $display("FAIL rstmid_gpr5: got %h want 00000000", gpr[5]);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_starvation();
        test_zero_write();
        test_collision();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
